// File: rtl/stopwatch_pkg.sv
// Shared encodings for the lap timer: FSM state type and its 2-bit codes.
package stopwatch_pkg;
   typedef enum logic [1:0] {
      IDLE    = 2'b00,
      RUNNING = 2'b01,
      PAUSED  = 2'b10,
      EXPIRED = 2'b11
   } state_t;
endpackage

// File: rtl/lap_fifo.sv
// Lap capture FIFO: power-of-2 depth, sticky overflow on a dropped push,
// push into a full FIFO is accepted when a pop happens in the same cycle.
module lap_fifo #(
   parameter int CNT_W     = 16,
   parameter int LAP_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             push,
   input  logic             ready,
   input  logic [CNT_W-1:0] din,
   output logic             valid,
   output logic [CNT_W-1:0] dout,
   output logic             full,
   output logic             overflow
);
   localparam int AW = $clog2(LAP_DEPTH);

   logic [CNT_W-1:0] mem [LAP_DEPTH];
   logic [AW:0]      wr_ptr, rd_ptr;
   logic             pop, push_ok;

   // Extra pointer bit distinguishes full from empty.
   assign valid   = (wr_ptr != rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout    = mem[rd_ptr[AW-1:0]];
   assign pop     = valid && ready;
   assign push_ok = push && (!full || pop);

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= din;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !push_ok)
            overflow <= 1'b1;
      end
   end
endmodule

// File: rtl/lap_timer_ctrl.sv
// Stopwatch / countdown controller with a prescaled tick and a lap capture FIFO.
module lap_timer_ctrl
   import stopwatch_pkg::*;
#(
   parameter int CNT_W     = 16,
   parameter int PRESCALE  = 1000,
   parameter int LAP_DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             stop,
   input  logic             reset,
   input  logic             lap,
   input  logic             mode_down,
   input  logic [CNT_W-1:0] load_val,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] count,
   output logic             tick,
   output logic             expired,
   output logic             lap_valid,
   output logic [CNT_W-1:0] lap_data,
   input  logic             lap_ready,
   output logic             lap_full,
   output logic             lap_overflow
);
   localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

   state_t        cur_st, nxt_st;
   logic [PW-1:0] presc;
   logic          mode_dn;
   logic          at_one;
   logic          push;

   assign at_one = (count == CNT_W'(1));
   assign state  = cur_st;

   always_ff @(posedge clk) begin
      if (!rst_n) cur_st <= IDLE;
      else        cur_st <= nxt_st;
   end

   // Expiry beats a same-cycle stop so the count never rests at 0 while paused.
   always_comb begin
      nxt_st = cur_st;
      if (reset)
         nxt_st = IDLE;
      else begin
         case (cur_st)
            IDLE:    if (start) nxt_st = (mode_down && load_val == '0) ? EXPIRED : RUNNING;
            RUNNING: if (tick && mode_dn && at_one) nxt_st = EXPIRED;
                     else if (stop)                 nxt_st = PAUSED;
            PAUSED:  if (start) nxt_st = RUNNING;
            default: nxt_st = cur_st;
         endcase
      end
   end

   always_comb begin
      tick    = (cur_st == RUNNING) && (presc == PMAX);
      expired = (cur_st == EXPIRED);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count   <= '0;
         presc   <= '0;
         mode_dn <= 1'b0;
      end else if (reset || cur_st == IDLE) begin
         count <= mode_down ? load_val : '0;
         presc <= '0;
         if (!reset && start)
            mode_dn <= mode_down;
      end else begin
         case (cur_st)
            RUNNING: begin
               presc <= (presc == PMAX) ? '0 : presc + 1'b1;
               if (tick) begin
                  if (!mode_dn)          count <= count + 1'b1;
                  else if (count != '0)  count <= count - 1'b1;
               end
            end
            EXPIRED: begin
               presc <= '0;
               count <= '0;
            end
            default: ;
         endcase
      end
   end

   assign push = lap && (cur_st == RUNNING || cur_st == PAUSED);

   lap_fifo #(.CNT_W(CNT_W), .LAP_DEPTH(LAP_DEPTH)) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (reset),
      .push     (push),
      .ready    (lap_ready),
      .din      (count),
      .valid    (lap_valid),
      .dout     (lap_data),
      .full     (lap_full),
      .overflow (lap_overflow)
   );
endmodule

// File: doc/lap_timer_ctrl.md
LAP_TIMER_CTRL -- requirements
Module: lap_timer_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, giving the elapsed/remaining tick count width.
REQ-002 SHALL have parameter PRESCALE, default 1000, giving clk cycles per tick; legal values are 1 or more.
REQ-003 SHALL have parameter LAP_DEPTH, default 4, giving lap FIFO entries; legal values are powers of 2, 2 or more.
REQ-004 SHALL have ports, in this order:
- clk  in  1  sole clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  start/resume pulse, debounced.
- stop  in  1  pause pulse.
- reset  in  1  user clear pulse.
- lap  in  1  lap capture pulse.
- mode_down  in  1  1 = countdown, 0 = count-up.
- load_val  in  CNT_W  countdown start value.
- state  out  2  FSM state.
- count  out  CNT_W  current tick count.
- tick  out  1  one-cycle prescaler pulse.
- expired  out  1  high while in EXPIRED.
- lap_valid  out  1  FIFO non-empty.
- lap_data  out  CNT_W  FIFO head value.
- lap_ready  in  1  consumer accepts head.
- lap_full  out  1  FIFO full.
- lap_overflow  out  1  sticky, a lap was dropped.

Function
REQ-005 SHALL implement the states IDLE=00, RUNNING=01, PAUSED=10, EXPIRED=11.
REQ-006 SHALL give reset top priority: reset high in any state moves the FSM to IDLE next cycle and clears the FIFO and lap_overflow.
REQ-007 SHALL apply these transitions in IDLE: start moves to RUNNING, except when mode_down=1 and load_val=0, where it moves directly to EXPIRED; stop and lap are ignored.
REQ-008 SHALL apply these transitions in RUNNING: stop moves to PAUSED; if start and stop arrive together, stop wins.
REQ-009 SHALL apply these transitions in PAUSED: start moves to RUNNING; if start and stop arrive together, start wins.
REQ-010 SHALL leave EXPIRED only on reset; start and stop are ignored there.
REQ-011 SHALL, in IDLE, load count every cycle with load_val if mode_down=1, else 0; the mode is latched on the IDLE-to-RUNNING edge and held until IDLE is re-entered.
REQ-012 SHALL run the prescaler 0..PRESCALE-1 only in RUNNING, hold it in PAUSED, and clear it in IDLE and EXPIRED; tick is high in the cycle the prescaler equals PRESCALE-1 while RUNNING.
REQ-013 SHALL update count on the clock edge ending a tick cycle: count-up increments and wraps from 2^CNT_W-1 to 0; countdown decrements.
REQ-014 SHALL, in countdown, move to EXPIRED on the edge where count goes 1 to 0; count then holds 0.
REQ-015 SHALL, when PRESCALE=1, assert tick on every RUNNING cycle.
REQ-016 SHALL, for lap in RUNNING or PAUSED, push the count value present in that cycle (before any same-cycle update); lap in IDLE or EXPIRED is ignored.
REQ-017 SHALL drop a push when the FIFO is full with no pop in the same cycle, and set lap_overflow.
REQ-018 SHALL pop on lap_valid and lap_ready; a simultaneous push and pop when full is accepted with no overflow.
REQ-019 SHALL present lap_data as the head entry whenever lap_valid=1, and hold lap_data stable until popped.
REQ-020 SHALL drive expired and lap_full combinationally from registered state only, with no combinational input-to-output paths except through the FIFO head.

Reset
REQ-021 SHALL, on rst_n=0 at a clock edge, set: state IDLE, count 0, prescaler 0, tick 0, mode count-up, FIFO empty, lap_valid 0, lap_full 0, lap_overflow 0.
REQ-022 SHALL let rst_n override all inputs, including mid-tick and mid-pop.

Structure
REQ-023 SHALL define the state encodings and the state typedef in the shared package stopwatch_pkg.
REQ-024 SHALL implement the lap FIFO as the sub-module lap_fifo, parameterised by CNT_W and LAP_DEPTH, with a clear input driven by reset.

Verification (CNT_W=8, PRESCALE=4, LAP_DEPTH=4)
REQ-025 SHALL check: start, 40 cycles, stop -> count=10, state=PAUSED; 3 more cycles -> count still 10.
REQ-026 SHALL check: up-count from 254 with 8 ticks -> wraps to 0 after the 2nd tick, ends at 6.
REQ-027 SHALL check: mode_down=1, load_val=3, start -> EXPIRED 12 cycles later, count=0, expired=1; start ignored, reset returns to IDLE with count=3.
REQ-028 SHALL check: 5 laps with lap_ready=0 -> lap_full=1, lap_overflow=1, and reads return the first 4 values in order.
REQ-029 SHALL check: start and stop together in RUNNING -> PAUSED; start and stop together in PAUSED -> RUNNING.
REQ-030 SHALL check: rst_n low mid-RUNNING with a full FIFO -> all REQ-021 values on the next edge.
